demux1t4_buf: RTL and testbench

Buffered 1-to-4 demultiplexer: accepts one 32-bit word per cycle on a valid/ready input port and steers it to one of four output ports chosen by a 2-bit select. It is the distribution counterpart to the datapath's 4:1 source muxes, used to fan a single producer (e.g. a load/response stream) out to four independent consumers. Each output has its own 2-entry FIFO, so a stalled consumer blocks only traffic addressed to it.

---
 rtl/demux_pkg.sv | 10 +
 rtl/fifo2_buf.sv | 51 +++++
 rtl/demux1t4_buf.sv | 59 +++++
 tb/tb_demux1t4_buf.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared widths and types for the buffered 1-to-4 demux
package demux_pkg;

  localparam int DW    = 32;
  localparam int DEPTH = 2;

  typedef logic [1:0]    port_sel_t;
  typedef logic [DW-1:0] data_t;

endpackage

// File: rtl/fifo2_buf.sv
// rtl/fifo2_buf.sv - two-entry FIFO with a zeroed head while empty
module fifo2_buf
  import demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  data_t wdata,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output data_t head
);

  data_t      mem [DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  // Guard both sides so a stray push/pop can never over- or underflow.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == 2'(DEPTH));
  assign empty = (count == 2'd0);
  assign head  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: empty masks stale entries off the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/demux1t4_buf.sv
// rtl/demux1t4_buf.sv - valid/ready 1-to-4 demux with a 2-entry FIFO per output
module demux1t4_buf
  import demux_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  port_sel_t sel,
  input  data_t     din,
  input  logic      in_vld,
  output logic      in_rdy,
  output data_t     dout0,
  output data_t     dout1,
  output data_t     dout2,
  output data_t     dout3,
  output logic      vld0,
  output logic      vld1,
  output logic      vld2,
  output logic      vld3,
  input  logic      rdy0,
  input  logic      rdy1,
  input  logic      rdy2,
  input  logic      rdy3,
  output logic      busy
);

  logic [3:0] push_a;
  logic [3:0] full_a;
  logic [3:0] empty_a;
  logic [3:0] rdy_a;
  data_t      head_a [4];

  assign rdy_a = {rdy3, rdy2, rdy1, rdy0};

  // Ready looks only at registered full flags, never at the consumer ready.
  assign in_rdy = rst_n && !full_a[sel];

  for (genvar g = 0; g < 4; g++) begin : g_port
    assign push_a[g] = in_vld && in_rdy && (sel == port_sel_t'(g));

    fifo2_buf u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_a[g]),
      .wdata (din),
      .pop   (rdy_a[g]),
      .full  (full_a[g]),
      .empty (empty_a[g]),
      .head  (head_a[g])
    );
  end

  assign {vld3, vld2, vld1, vld0} = ~empty_a;
  assign dout0 = head_a[0];
  assign dout1 = head_a[1];
  assign dout2 = head_a[2];
  assign dout3 = head_a[3];
  assign busy  = |(~empty_a);

endmodule

// File: tb/tb_demux1t4_buf.sv
// tb/tb_demux1t4_buf.sv - directed and randomized checks of demux1t4_buf
module tb_demux1t4_buf;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sel;
  logic [31:0] din;
  logic        in_vld;
  logic        in_rdy;
  logic [31:0] dout0, dout1, dout2, dout3;
  logic        vld0, vld1, vld2, vld3;
  logic        rdy0, rdy1, rdy2, rdy3;
  logic        busy;

  int passed;
  int total;

  logic [31:0] q [4][$];

  demux1t4_buf dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sel    (sel),
    .din    (din),
    .in_vld (in_vld),
    .in_rdy (in_rdy),
    .dout0  (dout0),
    .dout1  (dout1),
    .dout2  (dout2),
    .dout3  (dout3),
    .vld0   (vld0),
    .vld1   (vld1),
    .vld2   (vld2),
    .vld3   (vld3),
    .rdy0   (rdy0),
    .rdy1   (rdy1),
    .rdy2   (rdy2),
    .rdy3   (rdy3),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dout_of(input int p);
    case (p)
      0:       return dout0;
      1:       return dout1;
      2:       return dout2;
      default: return dout3;
    endcase
  endfunction

  function automatic logic vld_of(input int p);
    case (p)
      0:       return vld0;
      1:       return vld1;
      2:       return vld2;
      default: return vld3;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 2'd0; din = '0; in_vld = 1'b0;
    rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0; rdy3 = 1'b0;
    tick(); tick();
    total++;
    if ({vld3, vld2, vld1, vld0, busy, in_rdy} !== 6'b0) $display("FAIL reset_idle flags=%b want 000000", {vld3, vld2, vld1, vld0, busy, in_rdy});
    else passed++;
    rst_n = 1'b1;
    tick();
    // load ports 0 and 1, then yank reset between edges
    in_vld = 1'b1; sel = 2'd0; din = 32'h0000_00A0; tick();
    sel = 2'd1; din = 32'h0000_00A1; tick();
    in_vld = 1'b0;
    total++;
    if ({vld1, vld0, busy} !== 3'b111) $display("FAIL reset_preload flags=%b want 111", {vld1, vld0, busy});
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({vld3, vld2, vld1, vld0, busy, in_rdy} !== 6'b0) $display("FAIL reset_async flags=%b want 000000", {vld3, vld2, vld1, vld0, busy, in_rdy});
    else passed++;
    total++;
    if ((dout0 | dout1 | dout2 | dout3) !== 32'h0) $display("FAIL reset_dout or=%h want 0", dout0 | dout1 | dout2 | dout3);
    else passed++;
    tick();
    rst_n = 1'b1;
    sel = 2'd3; din = 32'h1234_5678; in_vld = 1'b1;
    #1;
    total++;
    if (in_rdy !== 1'b1) $display("FAIL reset_release_rdy in_rdy=%b want 1", in_rdy);
    else passed++;
    tick();
    in_vld = 1'b0;
    total++;
    if (vld3 !== 1'b1 || dout3 !== 32'h1234_5678 || vld0 !== 1'b0 || vld1 !== 1'b0) $display("FAIL reset_first_accept vld3=%b dout3=%h vld0=%b vld1=%b want 1 12345678 0 0", vld3, dout3, vld0, vld1);
    else passed++;
    rdy3 = 1'b1; tick(); rdy3 = 1'b0;
  endtask

  task automatic test_basic_route();
    sel = 2'd2; din = 32'hDEAD_BEEF; in_vld = 1'b1;
    #1;
    total++;
    if (in_rdy !== 1'b1) $display("FAIL basic_in_rdy in_rdy=%b want 1", in_rdy);
    else passed++;
    tick();
    in_vld = 1'b0;
    total++;
    if (vld2 !== 1'b1 || dout2 !== 32'hDEAD_BEEF || busy !== 1'b1) $display("FAIL basic_deliver vld2=%b dout2=%h busy=%b want 1 deadbeef 1", vld2, dout2, busy);
    else passed++;
    total++;
    if ({vld3, vld1, vld0} !== 3'b000) $display("FAIL basic_others vld3,1,0=%b want 000", {vld3, vld1, vld0});
    else passed++;
    rdy2 = 1'b1; tick(); rdy2 = 1'b0;
    total++;
    if (vld2 !== 1'b0 || dout2 !== 32'h0 || busy !== 1'b0) $display("FAIL basic_pop vld2=%b dout2=%h busy=%b want 0 0 0", vld2, dout2, busy);
    else passed++;
  endtask

  task automatic test_fill_backpressure();
    rdy1 = 1'b0; sel = 2'd1; in_vld = 1'b1;
    din = 32'h1; #1;
    total++;
    if (in_rdy !== 1'b1) $display("FAIL fill_first_rdy in_rdy=%b want 1", in_rdy);
    else passed++;
    tick();
    din = 32'h2; #1;
    total++;
    if (in_rdy !== 1'b1) $display("FAIL fill_second_rdy in_rdy=%b want 1", in_rdy);
    else passed++;
    tick();
    din = 32'h3; #1;
    total++;
    if (in_rdy !== 1'b0) $display("FAIL fill_third_blocked in_rdy=%b want 0", in_rdy);
    else passed++;
    tick();
    // full with consumer ready: still no pass-through
    rdy1 = 1'b1; #1;
    total++;
    if (in_rdy !== 1'b0 || dout1 !== 32'h1) $display("FAIL full_boundary in_rdy=%b dout1=%h want 0 00000001", in_rdy, dout1);
    else passed++;
    tick();
    total++;
    if (in_rdy !== 1'b1 || dout1 !== 32'h2) $display("FAIL after_first_pop in_rdy=%b dout1=%h want 1 00000002", in_rdy, dout1);
    else passed++;
    tick();
    in_vld = 1'b0;
    total++;
    if (vld1 !== 1'b1 || dout1 !== 32'h3) $display("FAIL third_accepted vld1=%b dout1=%h want 1 00000003", vld1, dout1);
    else passed++;
    tick();
    rdy1 = 1'b0;
    total++;
    if (vld1 !== 1'b0 || dout1 !== 32'h0) $display("FAIL fill_drained vld1=%b dout1=%h want 0 0", vld1, dout1);
    else passed++;
  endtask

  task automatic test_isolation();
    rdy0 = 1'b0; sel = 2'd0; in_vld = 1'b1;
    din = 32'hA000_0001; tick();
    din = 32'hA000_0002; tick();
    #1;
    total++;
    if (in_rdy !== 1'b0) $display("FAIL iso_port0_full in_rdy=%b want 0", in_rdy);
    else passed++;
    sel = 2'd3; din = 32'h0000_0033; #1;
    total++;
    if (in_rdy !== 1'b1) $display("FAIL iso_port3_rdy in_rdy=%b want 1", in_rdy);
    else passed++;
    tick();
    in_vld = 1'b0;
    total++;
    if (vld3 !== 1'b1 || dout3 !== 32'h33 || vld0 !== 1'b1 || dout0 !== 32'hA000_0001) $display("FAIL iso_deliver vld3=%b dout3=%h vld0=%b dout0=%h want 1 00000033 1 a0000001", vld3, dout3, vld0, dout0);
    else passed++;
    rdy3 = 1'b1; tick(); rdy3 = 1'b0;
    rdy0 = 1'b1;
    tick();
    total++;
    if (vld3 !== 1'b0 || dout0 !== 32'hA000_0002) $display("FAIL iso_port0_order vld3=%b dout0=%h want 0 a0000002", vld3, dout0);
    else passed++;
    tick();
    rdy0 = 1'b0;
    total++;
    if (vld0 !== 1'b0 || busy !== 1'b0) $display("FAIL iso_drained vld0=%b busy=%b want 0 0", vld0, busy);
    else passed++;
  endtask

  task automatic test_streaming();
    rdy0 = 1'b1; sel = 2'd0;
    for (int i = 0; i < 16; i++) begin
      din = 32'h10 + i; in_vld = 1'b1; #1;
      total++;
      if (in_rdy !== 1'b1) $display("FAIL stream_rdy[%0d] in_rdy=%b want 1", i, in_rdy);
      else passed++;
      tick();
      total++;
      if (vld0 !== 1'b1 || dout0 !== 32'h10 + i) $display("FAIL stream_word[%0d] vld0=%b dout0=%h want 1 %h", i, vld0, dout0, 32'h10 + i);
      else passed++;
    end
    in_vld = 1'b0;
    tick();
    rdy0 = 1'b0;
    total++;
    if (vld0 !== 1'b0 || busy !== 1'b0) $display("FAIL stream_end vld0=%b busy=%b want 0 0", vld0, busy);
    else passed++;
  endtask

  task automatic test_random();
    logic       pending;
    logic       exp_rdy;
    logic [3:0] r;
    int         errs;
    pending = 1'b0;
    errs = 0;
    for (int p = 0; p < 4; p++) q[p].delete();
    for (int c = 0; c < 10000; c++) begin
      if (!pending) begin
        sel = 2'($urandom_range(0, 3));
        din = $urandom;
        in_vld = ($urandom_range(0, 3) != 0);
      end
      r = 4'($urandom);
      {rdy3, rdy2, rdy1, rdy0} = r;
      #1;
      exp_rdy = (q[sel].size() < 2);
      if (errs < 20) begin
        total++;
        if (in_rdy !== exp_rdy) begin $display("FAIL rand_in_rdy cyc=%0d sel=%0d in_rdy=%b want %b", c, sel, in_rdy, exp_rdy); errs++; end
        else passed++;
        total++;
        if (busy !== (q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0)) begin $display("FAIL rand_busy cyc=%0d busy=%b", c, busy); errs++; end
        else passed++;
        for (int p = 0; p < 4; p++) begin
          total++;
          if (vld_of(p) !== (q[p].size() > 0)) begin $display("FAIL rand_vld cyc=%0d port=%0d vld=%b want %b", c, p, vld_of(p), q[p].size() > 0); errs++; end
          else if (q[p].size() > 0 && dout_of(p) !== q[p][0]) begin $display("FAIL rand_dout cyc=%0d port=%0d dout=%h want %h", c, p, dout_of(p), q[p][0]); errs++; end
          else if (q[p].size() == 0 && dout_of(p) !== 32'h0) begin $display("FAIL rand_dout_empty cyc=%0d port=%0d dout=%h want 0", c, p, dout_of(p)); errs++; end
          else passed++;
        end
      end
      for (int p = 0; p < 4; p++)
        if (r[p] && q[p].size() > 0) void'(q[p].pop_front());
      if (in_vld && exp_rdy) q[sel].push_back(din);
      pending = in_vld && !exp_rdy;
      @(posedge clk);
      #1;
    end
    in_vld = 1'b0;
    {rdy3, rdy2, rdy1, rdy0} = 4'hF;
    tick(); tick(); tick();
    total++;
    if (busy !== 1'b0) $display("FAIL rand_final_drain busy=%b want 0", busy);
    else passed++;
    {rdy3, rdy2, rdy1, rdy0} = 4'h0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_basic_route();
    test_fill_backpressure();
    test_isolation();
    test_streaming();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
